// File: rtl/awgn_pkg.sv
// Shared Q-format constants, FSM states and default widths for the AWGN channel LLR block.
package awgn_pkg;

    localparam int NOISE_FRAC = 11;
    localparam int SIGMA_FRAC = 15;
    localparam int BPSK_ONE   = 2048;

    localparam int DEF_NOISE_W    = 17;
    localparam int DEF_SIGMA_W    = 16;
    localparam int DEF_LLR_W      = 8;
    localparam int DEF_LLR_FRAC   = 2;
    localparam int DEF_FRAME_LEN  = 2304;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/awgn_out_fifo.sv
// Output FIFO for LLR pairs; push and pop may coincide when full. DEPTH must be a power of 2, >= 2.
module awgn_out_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Head is forced to zero when empty so the LLR outputs read 0 out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/awgn_channel_llr.sv
// BPSK + scaled AWGN -> saturated LLR pairs, one FSM pass per codeword.
// Optional AWGN_NOISE_BYPASS_EN adds noise_bypass to force clean-channel LLRs.
module awgn_channel_llr
    import awgn_pkg::*;
#(
    parameter int NOISE_W    = DEF_NOISE_W,
    parameter int SIGMA_W    = DEF_SIGMA_W,
    parameter int LLR_W      = DEF_LLR_W,
    parameter int LLR_FRAC   = DEF_LLR_FRAC,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [NOISE_W-1:0] noise0,
    input  logic signed [NOISE_W-1:0] noise1,
    input  logic [SIGMA_W-1:0]        sigma,
    input  logic                      frame_start,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    input  logic [1:0]                bits,
`ifdef AWGN_NOISE_BYPASS_EN
    input  logic                      noise_bypass,
`endif
    output logic                      llr_valid,
    input  logic                      llr_ready,
    output logic signed [LLR_W-1:0]   llr0,
    output logic signed [LLR_W-1:0]   llr1,
    output logic                      frame_done,
    output logic [15:0]               sat_count
);

    localparam int P_W   = NOISE_W + SIGMA_W;
    localparam int M_W   = P_W - SIGMA_FRAC + 1;
    localparam int Y_W   = M_W + 1;
    localparam int SHIFT = NOISE_FRAC - LLR_FRAC;
    localparam int Q_W   = Y_W + 1 - SHIFT;
    localparam int PAIRS = FRAME_LEN / 2;
    localparam int CNT_W = $clog2(PAIRS) + 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [P_W:0]   RND_P   = (P_W+1)'(2 ** (SIGMA_FRAC - 1));
    localparam logic [Y_W:0]   RND_Q   = (Y_W+1)'(2 ** (SHIFT - 1));
    localparam logic [Y_W-1:0] POS_ONE = Y_W'(BPSK_ONE);
    localparam logic [Y_W-1:0] NEG_ONE = Y_W'(-BPSK_ONE);

    state_e                     state, state_nxt;
    logic [SIGMA_W-1:0]         sigma_r;
    logic [CNT_W-1:0]           pair_cnt;
    logic                       accept, last_pair, s1_vld;
    logic [1:0][NOISE_W-1:0]    n_eff;
    logic [1:0][P_W-1:0]        prod_d, p_r;
    logic [1:0]                 b_r, sat_d;
    logic [1:0][LLR_W-1:0]      llr_d, fifo_rdata;
    logic [FCW-1:0]             fifo_count;
    logic                       fifo_empty, pop;
    logic [16:0]                sat_sum;

`ifdef AWGN_NOISE_BYPASS_EN
    assign n_eff = noise_bypass ? '0 : {noise1, noise0};
`else
    assign n_eff = {noise1, noise0};
`endif

    // Stage-1 occupancy counts against FIFO space so an accepted pair always has a slot.
    assign bit_ready = (state == RUN) && ((fifo_count + FCW'(s1_vld)) < FCW'(FIFO_DEPTH));
    assign accept    = bit_valid & bit_ready;
    assign last_pair = (pair_cnt == CNT_W'(PAIRS - 1));
    assign llr_valid = ~fifo_empty;
    assign pop       = llr_valid & llr_ready;
    assign {llr1, llr0} = fifo_rdata;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [P_W:0]   rsum;
        logic [M_W-1:0] m;
        logic [Y_W-1:0] y;
        logic [Y_W:0]   qsum;
        logic [Q_W-1:0] q;
        logic           ovf;

        assign prod_d[l] = P_W'($signed(n_eff[l])) * P_W'($signed({1'b0, sigma_r}));

        // Round-half-up then floor shift, on sign-extended two's complement bits.
        assign rsum = {p_r[l][P_W-1], p_r[l]} + RND_P;
        assign m    = M_W'(rsum >> SIGMA_FRAC);
        assign y    = {m[M_W-1], m} + (b_r[l] ? NEG_ONE : POS_ONE);
        assign qsum = {y[Y_W-1], y} + RND_Q;
        assign q    = Q_W'(qsum >> SHIFT);

        assign ovf      = !((&q[Q_W-1:LLR_W-1]) || !(|q[Q_W-1:LLR_W-1]));
        assign sat_d[l] = ovf;
        assign llr_d[l] = ovf ? (q[Q_W-1] ? {1'b1, {(LLR_W-1){1'b0}}}
                                          : {1'b0, {(LLR_W-1){1'b1}}})
                              : q[LLR_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld <= 1'b0;
            p_r    <= '0;
            b_r    <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                p_r <= prod_d;
                b_r <= bits;
            end
        end
    end

    awgn_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2 * LLR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (s1_vld),
        .wdata (llr_d),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign sat_sum = {1'b0, sat_count} + 17'(sat_d[0]) + 17'(sat_d[1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sigma_r   <= '0;
            pair_cnt  <= '0;
            sat_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && frame_start) begin
                sigma_r   <= sigma;
                pair_cnt  <= '0;
                sat_count <= '0;
            end else begin
                if (accept) pair_cnt <= pair_cnt + CNT_W'(1);
                if (s1_vld) sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (frame_start) state_nxt = RUN;
            RUN:   if (accept && last_pair) state_nxt = FLUSH;
            FLUSH: begin
                if (!s1_vld && fifo_empty) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/awgn_channel_llr.md
Name: awgn_channel_llr

Overview:
Consumer end of the AWGN generator. Takes the generator's free-running Gaussian pairs (x0/x1, signed Q5.11) and codeword bits from the LDPC encoder side. Forms BPSK channel samples y = (1-2b) + sigma*n, quantizes and saturates them, and delivers decoder-input LLR pairs under valid/ready handshake. Frame-based: one FSM pass per codeword.

Parameters:
NOISE_W, 17, noise sample width (signed Q5.11)
SIGMA_W, 16, sigma width (unsigned Q1.15, 0x8000 = 1.0)
LLR_W, 8, output LLR width (signed)
LLR_FRAC, 2, LLR fractional bits (fixed Q5.2 at default)
FRAME_LEN, 2304, codeword bits per frame (even, >= 4)
FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
noise0, noise1  in  NOISE_W  generator samples, new pair every cycle
sigma  in  SIGMA_W  noise std-dev, sampled on frame_start
frame_start  in  1  single-cycle frame start, honoured only in IDLE
bit_valid  in  1  codeword bit pair valid
bit_ready  out  1  pair accepted when bit_valid & bit_ready
bits  in  2  bits[0]->llr0, bits[1]->llr1
llr_valid  out  1  LLR pair available
llr_ready  in  1  downstream accept
llr0, llr1  out  LLR_W  signed channel LLRs
frame_done  out  1  one-cycle pulse at frame end
sat_count  out  16  saturated LLRs this frame

Behaviour:
- Reset (async assert, sync deassert expected upstream): state=IDLE; bit_ready=0, llr_valid=0, llr0=llr1=0, frame_done=0, sat_count=0; FIFO and pipe emptied.
- FSM IDLE -> RUN on frame_start: latch sigma, clear pair counter and sat_count. RUN -> FLUSH on acceptance of pair FRAME_LEN/2. FLUSH -> IDLE when pipe and FIFO are both empty; frame_done pulses on that transition cycle. frame_start in RUN/FLUSH is ignored.
- bit_ready = (state==RUN) & (fifo_count + pipe_valid_count < FIFO_DEPTH).
- Noise consumed only on accept. Samples on non-accept cycles are discarded.
- Pipe stage 1 (registered): p = noise * sigma_latched, 33-bit signed (sigma zero-extended).
- Pipe stage 2 (registered into FIFO):
  - m = (p + 2^14) >>> 15 (Q.11, 19 bit).
  - y = m + (b ? -2048 : +2048), 20 bit.
  - q = (y + 2^(10-LLR_FRAC)) >>> (11-LLR_FRAC).
  - Saturate to [-2^(LLR_W-1), 2^(LLR_W-1)-1].
- Latency: accept in cycle t -> llr_valid at t+2 when FIFO empty and llr_ready=1. Throughput is 1 pair/cycle.
- Outputs come from the FIFO head, stable while llr_valid & !llr_ready. Simultaneous push and pop at full is allowed, count unchanged. Order is preserved.
- sat_count increments by 0, 1 or 2 per pair (per lane clipped). Holds at 0xFFFF. Holds its value in IDLE until the next frame_start.

Optional Feature:
AWGN_NOISE_BYPASS_EN
- Defined: adds input port noise_bypass (1 bit, sampled per accept). When high, the noise term is forced to 0, giving clean-channel LLRs ±2^LLR_FRAC for decoder debug.
- Undefined: port absent; noise is always applied.

Decomposition:
- Package awgn_pkg:
  - Q-format constants: NOISE_FRAC=11, SIGMA_FRAC=15, BPSK_ONE=2048.
  - FSM state enum {IDLE, RUN, FLUSH}.
  - Default widths.
- Sub-module awgn_out_fifo: sync FIFO, FIFO_DEPTH x 2*LLR_W, exposes count, async active-low reset.

Test Plan:
1. sigma=0x0000; bits=00 then 11 -> llr0=llr1=+4, then -4; sat_count=0.
2. sigma=0x8000; noise0=0x00800 (+1.0), noise1=0x1F800 (-1.0); bits=00 -> llr0=8, llr1=0.
3. sigma=0xFFFF; noise0=0x0FFFF, noise1=0x10000; bits=00 -> llr0=127, llr1=-128, sat_count=2.
4. llr_ready=0 for 10 cycles with bit_valid=1 -> exactly 4 pairs accepted, bit_ready=0 thereafter; on release all 4 pairs emerge in order, none lost or duplicated.
5. FRAME_LEN=8; 4 pairs then bit_valid held high -> 5th pair not accepted; frame_done pulses once after the last LLR pop; state IDLE.
6. reset low mid-frame with FIFO holding 3 entries -> llr_valid, bit_ready, sat_count go 0 immediately. After release, no output until frame_start.
